// File: rtl/viterbi_ber_checker_if.sv
// viterbi_ber_checker_if: strobes in, lock/latency/count status out.
// master = stimulus side (drives bits), slave = checker (drives status).
interface viterbi_ber_checker_if #(
  parameter int MAX_LAT = 64,
  parameter int CNT_W   = 16
);
  localparam int LAT_W = $clog2(MAX_LAT);

  logic             src_bit_i;
  logic             src_valid_i;
  logic             dec_bit_i;
  logic             dec_valid_i;
  logic             clear_i;
  logic             locked_o;
  logic [LAT_W-1:0] latency_o;
  logic [CNT_W-1:0] bit_ct_o;
  logic [CNT_W-1:0] err_ct_o;
  logic             window_done_o;
  logic             lock_lost_o;
  logic [CNT_W-1:0] max_burst_o;

  modport master (
    output src_bit_i, src_valid_i, dec_bit_i, dec_valid_i, clear_i,
    input  locked_o, latency_o, bit_ct_o, err_ct_o,
    input  window_done_o, lock_lost_o, max_burst_o
  );

  modport slave (
    input  src_bit_i, src_valid_i, dec_bit_i, dec_valid_i, clear_i,
    output locked_o, latency_o, bit_ct_o, err_ct_o,
    output window_done_o, lock_lost_o, max_burst_o
  );
endinterface

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: aligns decoded bits to source history, counts BER.
// Ports: clk, rst (async high), bus (slave modport). Burst: VITERBI_BER_BURST_EN.
module viterbi_ber_checker #(
  parameter int MAX_LAT     = 64,
  parameter int SEARCH_LEN  = 32,
  parameter int LOCK_THRESH = 2,
  parameter int WIN         = 256,
  parameter int LOSS_THRESH = 32,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst,
  viterbi_ber_checker_if.slave bus
);
  localparam int LAT_W = $clog2(MAX_LAT);
  localparam int TR_W  = $clog2(SEARCH_LEN + 1);
  localparam int WIN_W = $clog2(WIN + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT - 1);

  logic [1:0]         state_q, state_d;
  logic [MAX_LAT-1:0] hist_q, hist_d;
  logic [LAT_W-1:0]   latency_q, latency_d;
  logic               locked_q, locked_d;
  logic [TR_W-1:0]    trial_n_q, trial_n_d;
  logic [TR_W-1:0]    trial_e_q, trial_e_d;
  logic [WIN_W-1:0]   win_n_q, win_n_d;
  logic [WIN_W-1:0]   win_e_q, win_e_d;
  logic [CNT_W-1:0]   bit_ct_q, bit_ct_d;
  logic [CNT_W-1:0]   err_ct_q, err_ct_d;
  logic               window_done_q, window_done_d;
  logic               lock_lost_q, lock_lost_d;

  logic             mism;
  logic [LAT_W-1:0] lat_next;

  // Reference uses the pre-shift history even when src_valid_i is high.
  assign mism     = bus.dec_bit_i ^ hist_q[latency_q];
  assign lat_next = (latency_q == LAT_MAX) ? '0
                                           : latency_q + LAT_W'(1);

  always_comb begin
    hist_d        = hist_q;
    state_d       = state_q;
    latency_d     = latency_q;
    locked_d      = locked_q;
    trial_n_d     = trial_n_q;
    trial_e_d     = trial_e_q;
    win_n_d       = win_n_q;
    win_e_d       = win_e_q;
    bit_ct_d      = bit_ct_q;
    err_ct_d      = err_ct_q;
    window_done_d = 1'b0;
    lock_lost_d   = 1'b0;

    if (bus.src_valid_i) begin
      hist_d = {hist_q[MAX_LAT-2:0], bus.src_bit_i};
    end

    unique case (1'b1)
      (state_q == ST_IDLE): begin
        // First decoded bit only starts the search; it is not compared.
        if (bus.dec_valid_i) begin
          state_d   = ST_SEARCH;
          latency_d = '0;
          trial_n_d = '0;
          trial_e_d = '0;
        end
      end
      (state_q == ST_SEARCH): begin
        if (bus.dec_valid_i) begin
          trial_n_d = trial_n_q + TR_W'(1);
          trial_e_d = trial_e_q + TR_W'(mism);
          if (trial_n_q == TR_W'(SEARCH_LEN - 1)) begin
            trial_n_d = '0;
            trial_e_d = '0;
            if (trial_e_q + TR_W'(mism) <= TR_W'(LOCK_THRESH)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              win_n_d  = '0;
              win_e_d  = '0;
            end else begin
              latency_d = lat_next;
            end
          end
        end
      end
      (state_q == ST_LOCKED): begin
        if (bus.dec_valid_i) begin
          if (bit_ct_q != CNT_MAX) bit_ct_d = bit_ct_q + CNT_W'(1);
          if (mism && err_ct_q != CNT_MAX) begin
            err_ct_d = err_ct_q + CNT_W'(1);
          end
          win_n_d = win_n_q + WIN_W'(1);
          win_e_d = win_e_q + WIN_W'(mism);
          if (win_n_q == WIN_W'(WIN - 1)) begin
            window_done_d = 1'b1;
            win_n_d       = '0;
            win_e_d       = '0;
            if (win_e_q + WIN_W'(mism) > WIN_W'(LOSS_THRESH)) begin
              lock_lost_d = 1'b1;
              locked_d    = 1'b0;
              latency_d   = lat_next;
              state_d     = ST_SEARCH;
              trial_n_d   = '0;
              trial_e_d   = '0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear overrides any count from a same-cycle compare.
    if (bus.clear_i) begin
      bit_ct_d = '0;
      err_ct_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hist_q        <= '0;
      latency_q     <= '0;
      locked_q      <= 1'b0;
      trial_n_q     <= '0;
      trial_e_q     <= '0;
      win_n_q       <= '0;
      win_e_q       <= '0;
      bit_ct_q      <= '0;
      err_ct_q      <= '0;
      window_done_q <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      latency_q     <= latency_d;
      locked_q      <= locked_d;
      trial_n_q     <= trial_n_d;
      trial_e_q     <= trial_e_d;
      win_n_q       <= win_n_d;
      win_e_q       <= win_e_d;
      bit_ct_q      <= bit_ct_d;
      err_ct_q      <= err_ct_d;
      window_done_q <= window_done_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign bus.locked_o      = locked_q;
  assign bus.latency_o     = latency_q;
  assign bus.bit_ct_o      = bit_ct_q;
  assign bus.err_ct_o      = err_ct_q;
  assign bus.window_done_o = window_done_q;
  assign bus.lock_lost_o   = lock_lost_q;

`ifdef VITERBI_BER_BURST_EN
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] max_burst_q, max_burst_d;

  always_comb begin
    run_d       = run_q;
    max_burst_d = max_burst_q;
    if (state_q == ST_LOCKED && bus.dec_valid_i) begin
      if (mism) begin
        if (run_q != CNT_MAX) run_d = run_q + CNT_W'(1);
      end else begin
        run_d = '0;
      end
      if (run_d > max_burst_q) max_burst_d = run_d;
    end
    if (state_q != ST_LOCKED && state_d == ST_LOCKED) run_d = '0;
    if (bus.clear_i) max_burst_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= '0;
      max_burst_q <= '0;
    end else begin
      run_q       <= run_d;
      max_burst_q <= max_burst_d;
    end
  end

  assign bus.max_burst_o = max_burst_q;
`else
  assign bus.max_burst_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker: directed bench with a count scoreboard.
// Decoder is modelled as a delay line on the bench's own source log.
`timescale 1ns/1ps
module tb_viterbi_ber_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_ber_checker_if bus ();

  viterbi_ber_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef VITERBI_BER_BURST_EN
  localparam int BURST_EXP = 5;
  localparam int ONE_EXP   = 1;
`else
  localparam int BURST_EXP = 0;
  localparam int ONE_EXP   = 0;
`endif

  typedef struct {
    int b;
    int e;
  } exp_t;

  int   checks  = 0;
  int   errors  = 0;
  int   d_lat   = 20;
  bit   track   = 1'b0;
  int   exp_bit = 0;
  int   exp_err = 0;
  int   wd_n    = 0;
  int   ll_n    = 0;
  bit   src_log[$];
  exp_t sb_q[$];
  bit   pat[22] = '{1,0,0,0,0,0,1,1,0,0,0,
                    0,0,1,1,1,1,1,0,0,0,0};

  task automatic chk(input string tag, input logic [31:0] got,
                     input int want);
    checks++;
    assert (got === 32'(want)) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // One clock: dv strobes decode, inv flips the decoded bit,
  // clr pulses clear_i, frc forces src=0/dec=1 (always mismatch).
  task automatic cyc(input bit dv, input bit inv, input bit clr,
                     input bit frc);
    bit   sb;
    bit   rb;
    bit   iv;
    exp_t e;
    sb = 1'($urandom);
    iv = inv;
    rb = (src_log.size() > d_lat) ?
         src_log[src_log.size() - 1 - d_lat] : 1'b0;
    if (frc) begin
      sb = 1'b0;
      rb = 1'b0;
      iv = 1'b1;
    end
    bus.src_bit_i   = sb;
    bus.src_valid_i = 1'b1;
    bus.dec_bit_i   = rb ^ iv;
    bus.dec_valid_i = dv;
    bus.clear_i     = clr;
    if (track) begin
      if (clr) begin
        exp_bit = 0;
        exp_err = 0;
      end else if (dv) begin
        exp_bit++;
        exp_err += int'(iv);
      end
      e.b = exp_bit;
      e.e = exp_err;
      sb_q.push_back(e);
    end
    @(posedge clk);
    src_log.push_back(sb);
    #1;
    if (bus.window_done_o) wd_n++;
    if (bus.lock_lost_o) ll_n++;
    if (track) begin
      e = sb_q.pop_front();
      chk("sb_bit_ct", 32'(bus.bit_ct_o), e.b);
      chk("sb_err_ct", 32'(bus.err_ct_o), e.e);
    end
  endtask

  task automatic do_reset();
    #1;
    rst             = 1'b1;
    bus.src_valid_i = 1'b0;
    bus.dec_valid_i = 1'b0;
    bus.clear_i     = 1'b0;
    #2;
    rst = 1'b0;
    src_log.delete();
    track = 1'b0;
  endtask

  task automatic wait_lock(input string tag, input int want_n,
                           input int want_lat);
    int n;
    n = 0;
    do begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!bus.locked_o && n < 2000);
    chk({tag, "_steps"}, 32'(n), want_n);
    chk({tag, "_lat"}, 32'(bus.latency_o), want_lat);
    chk({tag, "_locked"}, 32'(bus.locked_o), 1);
  endtask

  initial begin
    int n;
    int w0;
    int l0;
    bus.src_bit_i   = 1'b0;
    bus.src_valid_i = 1'b0;
    bus.dec_bit_i   = 1'b0;
    bus.dec_valid_i = 1'b0;
    bus.clear_i     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_locked", 32'(bus.locked_o), 0);
    chk("rst_lat", 32'(bus.latency_o), 0);
    chk("rst_bit", 32'(bus.bit_ct_o), 0);
    chk("rst_err", 32'(bus.err_ct_o), 0);
    chk("rst_wd", 32'(bus.window_done_o), 0);
    chk("rst_ll", 32'(bus.lock_lost_o), 0);
    chk("rst_burst", 32'(bus.max_burst_o), 0);

    // Clean channel, latency 20: idle exit + 21 trials of 32.
    d_lat = 20;
    wait_lock("lock20", 1 + 21 * 32, 20);
    exp_bit = 0;
    exp_err = 0;
    track   = 1'b1;
    wd_n    = 0;
    ll_n    = 0;
    for (int i = 1; i <= 1000; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clean_bit", 32'(bus.bit_ct_o), 1000);
    chk("clean_err", 32'(bus.err_ct_o), 0);
    chk("clean_wd", 32'(wd_n), 3);
    chk("clean_ll", 32'(ll_n), 0);
    chk("clean_burst", 32'(bus.max_burst_o), 0);

    // Fresh lock, then invert every 64th compare.
    do_reset();
    wait_lock("lock20b", 1 + 21 * 32, 20);
    exp_bit = 0;
    exp_err = 0;
    track   = 1'b1;
    wd_n    = 0;
    ll_n    = 0;
    for (int i = 1; i <= 1000; i++) begin
      cyc(1'b1, (i % 64) == 0, 1'b0, 1'b0);
    end
    chk("inj_bit", 32'(bus.bit_ct_o), 1000);
    chk("inj_err", 32'(bus.err_ct_o), 15);
    chk("inj_wd", 32'(wd_n), 3);
    chk("inj_ll", 32'(ll_n), 0);

    // Clear on the same cycle as a mismatch.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_bit", 32'(bus.bit_ct_o), 0);
    chk("clr_err", 32'(bus.err_ct_o), 0);
    chk("clr_locked", 32'(bus.locked_o), 1);

    // Align to a window boundary, then move the decoder to 23.
    track = 1'b0;
    w0 = wd_n;
    n  = 0;
    while (wd_n == w0 && n < 300) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("align_wd", 32'(wd_n - w0), 1);
    d_lat = 23;
    l0 = ll_n;
    n  = 0;
    while (ll_n == l0 && n < 600) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("loss_n", 32'(n), 256);
    chk("loss_locked", 32'(bus.locked_o), 0);
    chk("loss_lat", 32'(bus.latency_o), 21);
    n = 0;
    while (!bus.locked_o && n < 400) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("relock_n", 32'(n), 3 * 32);
    chk("relock_lat", 32'(bus.latency_o), 23);

    // Error bursts of 1, 2 and 5 while locked.
    track = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("burst_clr", 32'(bus.max_burst_o), 0);
    cyc(1'b1, pat[0], 1'b0, 1'b0);
    chk("burst_one", 32'(bus.max_burst_o), ONE_EXP);
    for (int i = 1; i < 22; i++) cyc(1'b1, pat[i], 1'b0, 1'b0);
    chk("burst_bit", 32'(bus.bit_ct_o), 22);
    chk("burst_err", 32'(bus.err_ct_o), 8);
    chk("burst_max", 32'(bus.max_burst_o), BURST_EXP);

    // Async reset mid-search at latency 7.
    do_reset();
    n = 0;
    while (bus.latency_o != 7 && n < 400) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("lat7_n", 32'(n), 1 + 7 * 32);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_lat", 32'(bus.latency_o), 0);
    chk("arst_locked", 32'(bus.locked_o), 0);
    chk("arst_bit", 32'(bus.bit_ct_o), 0);
    chk("arst_err", 32'(bus.err_ct_o), 0);
    chk("arst_wd", 32'(bus.window_done_o), 0);
    chk("arst_ll", 32'(bus.lock_lost_o), 0);
    chk("arst_burst", 32'(bus.max_burst_o), 0);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_lat", 32'(bus.latency_o), 0);
    repeat (32) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("first_uncmp", 32'(bus.latency_o), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("trial_step", 32'(bus.latency_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Receive-side checker for the encoder → channel → Viterbi decoder chain.
- Keeps a history of source bits fed to the encoder and finds the decoder's pipeline latency automatically.
- Once aligned, compares every decoded bit against the matching source bit and counts bits and errors.
- Flags lock and loss of lock, so benches and on-chip self-test get a post-decoder BER without hand-tuned delays.

Parameters:
- MAX_LAT, 64: depth of the source history. Candidate latencies are 0..MAX_LAT-1, measured in source-valid strobes.
- SEARCH_LEN, 32: compared bits per candidate latency during search.
- LOCK_THRESH, 2: maximum errors in a SEARCH_LEN trial that still declares lock.
- WIN, 256: window length, in compared bits, for loss-of-lock evaluation.
- LOSS_THRESH, 32: window errors strictly above this declare loss of lock.
- CNT_W, 16: width of the bit and error counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- src_bit_i  input  1  source bit presented to the encoder.
- src_valid_i  input  1  src_bit_i is valid this cycle.
- dec_bit_i  input  1  decoded bit from the Viterbi decoder.
- dec_valid_i  input  1  dec_bit_i is valid this cycle.
- clear_i  input  1  synchronous clear of bit_ct_o, err_ct_o and max_burst_o. Lock state is unaffected.
- locked_o  output  1  alignment found.
- latency_o  output  $clog2(MAX_LAT)  current or locked candidate latency.
- bit_ct_o  output  CNT_W  bits compared while locked; saturating.
- err_ct_o  output  CNT_W  mismatches while locked; saturating.
- window_done_o  output  1  one-cycle pulse at the end of each WIN window in LOCKED.
- lock_lost_o  output  1  one-cycle pulse when LOCKED falls back to SEARCH.
- max_burst_o  output  CNT_W  longest run of consecutive mismatches (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0.
  - History register 0.
  - State IDLE.
  - All internal counters 0.
- History:
  - On src_valid_i, hist <= {hist[MAX_LAT-2:0], src_bit_i}.
  - hist[k] is the source bit from k+1 strobes earlier.
- Compare event:
  - Occurs on a cycle with dec_valid_i=1, ref = hist[latency_o].
  - When src_valid_i and dec_valid_i are both high in the same cycle, compare against the pre-shift hist.
- IDLE:
  - Leave on the first dec_valid_i and go to SEARCH with latency_o=0, trial counters 0.
  - That first bit is not compared.
- SEARCH:
  - Count compare events and mismatches for the current trial.
  - After SEARCH_LEN events with mismatches <= LOCK_THRESH: go to LOCKED, locked_o=1 from the next cycle, latency_o held.
  - Otherwise: latency_o increments and wraps from MAX_LAT-1 to 0, trial counters clear, stay in SEARCH.
- LOCKED:
  - Each compare event increments bit_ct_o, plus err_ct_o on mismatch. Both saturate at 2^CNT_W-1.
  - A window counter counts compare events.
  - On the WIN-th event, pulse window_done_o.
  - If window errors > LOSS_THRESH in that same cycle: pulse lock_lost_o, locked_o=0, latency_o increments with wrap, go to SEARCH.
  - bit_ct_o and err_ct_o keep their values across loss of lock.
- clear_i:
  - Zeroes the counters.
  - If a compare event occurs in the same cycle, clear wins and that event is not counted.
- Reset mid-operation returns to the reset values immediately, asynchronously.
- No backpressure: the checker always accepts both strobes.

Optional Feature:
- Macro: VITERBI_BER_BURST_EN.
- Defined:
  - In LOCKED, a run counter increments on each mismatch and clears on each match.
  - max_burst_o <= max(max_burst_o, run), saturating; cleared by clear_i.
  - The run counter clears on entry to LOCKED.
- Undefined: max_burst_o is tied to 0 and no run logic is built.

Test Plan:
- Clean channel, decoder latency 20, both valids every cycle: locked_o=1 after 21 trials; latency_o=20; after 1000 locked bits, err_ct_o=0 and bit_ct_o=1000.
- Same setup with dec_bit_i inverted on every 64th compare in LOCKED: err_ct_o=15 after 1000 bits; no lock_lost_o pulse; 3 window_done_o pulses.
- Locked at 20, then latency changes to 23: lock_lost_o pulses within 256 compares; relock with latency_o=23.
- clear_i asserted on the same cycle as a mismatch: bit_ct_o=0 and err_ct_o=0 on the next cycle.
- rst asserted mid-SEARCH at latency_o=7: all outputs 0 immediately; IDLE until the next dec_valid_i.
- With VITERBI_BER_BURST_EN defined, inject 1 error, then a burst of 2, then a burst of 5 while LOCKED: max_burst_o=5. With the macro undefined: max_burst_o=0.
